// File: rtl/motor_pkg.sv
// motor_pkg: register map, FSM states and coil tables for motor_step_sequencer
package motor_pkg;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_PERIOD   = 3'd1;
    localparam logic [2:0] ADDR_STEPS    = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_POSITION = 3'd5;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_DIR  = 1;
    localparam int CTRL_HALF = 2;
    localparam int CTRL_HOLD = 3;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_LIM  = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Entry 0 sits in the least significant nibble
    localparam logic [15:0] FULL_TBL = {4'b1001, 4'b1100, 4'b0110, 4'b0011};
    localparam logic [31:0] HALF_TBL = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                        4'b0110, 4'b0010, 4'b0011, 4'b0001};

    function automatic logic [3:0] full_coils(input logic [1:0] idx);
        return FULL_TBL[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] half_coils(input logic [2:0] idx);
        return HALF_TBL[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/motor_step_timer.sv
// motor_step_timer: reloadable down-counter emitting a one-cycle tick every period_i cycles
module motor_step_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         run_i,
    input  logic [W-1:0] period_i,
    output logic         tick_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == W'(1));

    // Load at start, reload on tick, otherwise count down while running
    always_comb begin
        cnt_d = (load_i || tick_o) ? period_i : ((run_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q);
    end

    // Counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/motor_step_sequencer.sv
// motor_step_sequencer: Avalon-MM stepper sequencer; HALF_STEP_EN enables the 8-entry half-step table
module motor_step_sequencer
    import motor_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int STEP_W   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic [1:0]  limit,
    output logic [3:0]  coils
);
`ifdef HALF_STEP_EN
    localparam int PH_W = 3;
`else
    localparam int PH_W = 2;
`endif

    state_t              state_q, state_d;
    logic                dir_q, dir_d, half_q, half_d, hold_q, hold_d;
    logic [PERIOD_W-1:0] period_q, period_d, eff_period;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                done_q, done_d, lim_q, lim_d;
    logic [1:0]          mask_q, mask_d;
    logic [31:0]         pos_q, pos_d, rd_val, readdata_q, readdata_d;
    logic [PH_W-1:0]     phase_q, phase_d, ph_inc, ph_start;
    logic [3:0]          coils_q, coils_d;
    logic [1:0]          lim_s1_q, lim_s2_q;
    logic                wr, rd, busy, ctrl_wr, start, zero_start, abort, tick, blocked;

    assign wr         = chipselect && !write_n;
    assign rd         = chipselect && write_n;
    assign busy       = (state_q == S_RUN);
    assign ctrl_wr    = wr && (address == ADDR_CTRL);
    assign start      = ctrl_wr && writedata[CTRL_RUN] && !busy && (steps_q != '0);
    assign zero_start = ctrl_wr && writedata[CTRL_RUN] && !busy && (steps_q == '0);
    assign abort      = ctrl_wr && !writedata[CTRL_RUN] && busy;
    assign blocked    = tick && (dir_q ? lim_s2_q[1] : lim_s2_q[0]);
    assign eff_period = (period_q < PERIOD_W'(2)) ? PERIOD_W'(2) : period_q;
    assign irq        = |({lim_q, done_q} & mask_q);
    assign readdata   = readdata_q;
    assign coils      = coils_q;

`ifdef HALF_STEP_EN
    // Full-step mode walks the odd (two-coil) entries two at a time
    assign ph_inc   = half_q ? 3'd1 : 3'd2;
    assign ph_start = writedata[CTRL_HALF] ? phase_q : (phase_q | 3'd1);
`else
    assign ph_inc   = 2'd1;
    assign ph_start = phase_q;
`endif

    assign rd_val = (address == ADDR_CTRL)     ? {28'd0, hold_q, half_q, dir_q, busy} :
                    (address == ADDR_PERIOD)   ? 32'(period_q) :
                    (address == ADDR_STEPS)    ? 32'(steps_q) :
                    (address == ADDR_STATUS)   ? {29'd0, lim_q, done_q, busy} :
                    (address == ADDR_IRQ_MASK) ? {30'd0, mask_q} :
                    (address == ADDR_POSITION) ? pos_q : 32'd0;

    motor_step_timer #(.W(PERIOD_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (start),
        .run_i    (busy),
        .period_i (eff_period),
        .tick_o   (tick)
    );

    // Register writes, then FSM events; status sets come last so they beat a same-cycle W1C
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        half_d     = half_q;
        hold_d     = hold_q;
        period_d   = period_q;
        steps_d    = steps_q;
        done_d     = done_q;
        lim_d      = lim_q;
        mask_d     = mask_q;
        pos_d      = pos_q;
        phase_d    = phase_q;
        readdata_d = rd ? rd_val : readdata_q;
        if (ctrl_wr) begin
            dir_d  = writedata[CTRL_DIR];
            hold_d = writedata[CTRL_HOLD];
`ifdef HALF_STEP_EN
            half_d = writedata[CTRL_HALF];
`endif
        end
        if (wr && address == ADDR_PERIOD) period_d = writedata[PERIOD_W-1:0];
        if (wr && address == ADDR_STEPS && !busy) steps_d = writedata[STEP_W-1:0];
        if (wr && address == ADDR_STATUS && writedata[ST_DONE]) done_d = 1'b0;
        if (wr && address == ADDR_STATUS && writedata[ST_LIM]) lim_d = 1'b0;
        if (wr && address == ADDR_IRQ_MASK) mask_d = writedata[1:0];
        if (wr && address == ADDR_POSITION && !busy) pos_d = writedata;
        if (start) begin
            state_d = S_RUN;
            phase_d = ph_start;
        end else if (zero_start) begin
            done_d = 1'b1;
        end else if (abort) begin
            state_d = S_IDLE;
        end else if (blocked) begin
            state_d = S_IDLE;
            lim_d   = 1'b1;
        end else if (tick) begin
            phase_d = dir_q ? phase_q + ph_inc : phase_q - ph_inc;
            steps_d = steps_q - STEP_W'(1);
            pos_d   = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
            if (steps_q == STEP_W'(1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
`ifdef HALF_STEP_EN
        coils_d = (state_d == S_RUN || hold_d) ? half_coils(phase_d) : 4'b0000;
`else
        coils_d = (state_d == S_RUN || hold_d) ? full_coils(phase_d) : 4'b0000;
`endif
    end

    // State and register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            half_q     <= 1'b0;
            hold_q     <= 1'b0;
            period_q   <= '0;
            steps_q    <= '0;
            done_q     <= 1'b0;
            lim_q      <= 1'b0;
            mask_q     <= '0;
            pos_q      <= '0;
            phase_q    <= '0;
            coils_q    <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            half_q     <= half_d;
            hold_q     <= hold_d;
            period_q   <= period_d;
            steps_q    <= steps_d;
            done_q     <= done_d;
            lim_q      <= lim_d;
            mask_q     <= mask_d;
            pos_q      <= pos_d;
            phase_q    <= phase_d;
            coils_q    <= coils_d;
            readdata_q <= readdata_d;
        end
    end

    // Two-flop synchronizer for the asynchronous limit switches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lim_s1_q <= '0;
            lim_s2_q <= '0;
        end else begin
            lim_s1_q <= limit;
            lim_s2_q <= lim_s1_q;
        end
    end
endmodule

// File: doc/motor_step_sequencer.md
# motor_step_sequencer

Avalon-MM slave that drives a 4-coil unipolar stepper motor. Software loads step count, step period and direction; the block generates the coil phase pattern autonomously, tracks position, and stops on count exhaustion or a limit switch. It sits beside the GPIO input port on the same Avalon bus: the port samples the switches, and this block owns the coil outputs and the motion sequencing.

## Interface
- PERIOD_W, 24: width of the step-period register, in clk cycles.
- STEP_W, 16: width of the step-count register.
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  3  register select, word index.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.
- limit  in  2  raw limit switches, active-high, asynchronous to clk.
  - [0]: reverse end.
  - [1]: forward end.
- coils  out  4  coil drive, active-high.

## Operation
- Registers (address):
  - 0 CTRL: bit0 run, bit1 dir (1 = forward), bit2 half, bit3 hold.
  - 1 PERIOD: PERIOD_W bits.
  - 2 STEPS: write sets the count; read returns steps remaining.
  - 3 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 lim_stop (W1C).
  - 4 IRQ_MASK: bit0 done, bit1 lim_stop.
  - 5 POSITION: signed 32-bit. Writable only in IDLE; writes ignored in RUN.
  - 6–7: reserved; read 0.
- Effective period is max(PERIOD, 2).
- FSM states are IDLE and RUN.
- IDLE→RUN on a CTRL write with run=1 and STEPS≠0. On entry, the timer loads the effective period.
- A CTRL write with run=1 and STEPS=0 sets done; there is no motion.
- A CTRL write with run=1 while in RUN is ignored apart from the field updates below.
- RUN step tick occurs when the timer expires. At each tick:
  - phase index advances +1 if dir=1, −1 if dir=0, wrapping;
  - STEPS decrements;
  - POSITION moves ±1 (32-bit wrap);
  - timer reloads.
- RUN→IDLE when STEPS reaches 0 at a tick; done is set.
- RUN→IDLE on a CTRL write with run=0. This is an abort: done is not set and STEPS keeps the remaining count.
- Limit handling:
  - limit passes through a 2-FF synchronizer.
  - At a tick, if the synchronized limit in the direction of motion is high, the step is not taken. lim_stop is set, the FSM goes to IDLE, and done is not set.
  - The limit opposite to the direction of motion is ignored.
- Coil patterns:
  - Full-step table, index 0–3: 0011, 0110, 1100, 1001.
  - Half-step table, index 0–7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- In IDLE, coils hold the current pattern if hold=1, else drive 0000.
- dir, hold and PERIOD writes during RUN take effect at the next tick or reload. STEPS writes during RUN are ignored.
- irq = |(STATUS[2:1] & IRQ_MASK[1:0]).
- If a W1C clear and a set of the same bit occur in the same cycle, the set wins.

## Timing
- Reset values: all registers 0, FSM in IDLE, phase index 0, coils 0000, readdata 0, irq 0.
- readdata is registered: valid the cycle after chipselect with write_n high. Read has no side effects.
- First tick occurs exactly effective-period cycles after the start-write cycle. Subsequent ticks are spaced by the effective period.
- coils and POSITION update in the cycle after a tick.
- busy, done and irq update in the cycle after the terminal tick.
- Limit latency: 2 cycles of synchronizer, then the limit is sampled at the next tick.
- reset_n asserted mid-RUN: immediate IDLE, coils 0000, no status retained.

## Configuration
- HALF_STEP_EN defined:
  - phase index is 3 bits over the half-step table;
  - half=1 steps ±1;
  - half=0 steps ±2, and at RUN entry the index is forced odd (index|1) so full-step output matches the two-coil patterns.
- HALF_STEP_EN undefined:
  - phase index is 2 bits over the full-step table;
  - CTRL bit2 is not stored and reads 0.

## Structure
- Package motor_pkg holds:
  - register address constants and STATUS/CTRL bit positions;
  - FSM state enum;
  - full-step and half-step coil tables.
- Sub-module motor_step_timer: reloadable down-counter that takes the effective period and outputs a one-cycle tick pulse.
- The synchronizer, register file, FSM and phase logic stay in the top module.

## Test plan
- PERIOD=4, STEPS=3, dir=1, full mode, start → coils 0011→0110→1100 (first change 5 cycles after the start write), POSITION=3, done=1, busy=0.
- dir=0 from index 0, STEPS=2 → coils 1001, then 1100; POSITION=−2 (0xFFFFFFFE).
- STEPS=10, dir=1, limit[1] raised mid-run → at most 1 further step, then lim_stop=1, done=0, STEPS>0, irq=1 when IRQ_MASK=2.
- PERIOD=0, STEPS=2 → ticks 2 cycles apart; a CTRL run=0 write after the first tick → IDLE, STEPS=1, done=0.
- Start with STEPS=0 → done=1, coils unchanged, busy never asserted. Then W1C done in the same cycle as a new done event → done stays 1.
- HALF_STEP_EN, half=1, STEPS=8 → all 8 half-step patterns in sequence, returning to index 0; hold=0 → coils 0000 after done.
